// File: rtl/mem_stage.sv
// Memory-access stage: waits for the data-SRAM response, aligns and extends load data and drives the writeback bus.
// Optional forwarding view to decode is enabled by defining MS_FORWARD_EN.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 75,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ms_fwd_valid,
  output logic [4:0]                 ms_fwd_dest,
  output logic [31:0]                ms_fwd_data,
  output logic                       ms_fwd_stall
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                     state, state_nxt;
  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic [31:0]                rdata_buf;
  logic                       rdata_capture;

  logic        mem_req;
  logic [2:0]  ld_type;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign mem_req      = bus_r[74];
  assign ld_type      = bus_r[73:71];
  assign res_from_mem = bus_r[70];
  assign gr_we        = bus_r[69];
  assign dest         = bus_r[68:64];
  assign alu_result   = bus_r[63:32];
  assign pc           = bus_r[31:0];

  logic ms_ready_go;
  logic accept;
  logic leave;

  assign ms_ready_go    = !mem_req || (state == DONE) || (state == WAIT && data_sram_data_ok);
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;
  assign accept         = es_to_ms_valid && ms_allowin;
  assign leave          = ms_to_ws_valid && ws_allowin;

  logic [31:0] ld_src;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] final_result;

  assign ld_src = (state == DONE) ? rdata_buf : data_sram_rdata;

  always_comb begin
    ld_byte = ld_src[7:0];
    case (alu_result[1:0])
      2'd1:    ld_byte = ld_src[15:8];
      2'd2:    ld_byte = ld_src[23:16];
      2'd3:    ld_byte = ld_src[31:24];
      default: ld_byte = ld_src[7:0];
    endcase
    ld_half = alu_result[1] ? ld_src[31:16] : ld_src[15:0];
    case (ld_type)
      3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd2:    ld_data = {24'd0, ld_byte};
      3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {16'd0, ld_half};
      default: ld_data = ld_src;
    endcase
  end

  assign final_result = res_from_mem ? ld_data : alu_result;
  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};

  // A new instruction overrides everything; a response seen while writeback stalls is parked in DONE.
  always_comb begin
    state_nxt     = state;
    rdata_capture = 1'b0;
    if (accept) begin
      state_nxt = es_to_ms_bus[74] ? WAIT : IDLE;
    end else if (leave) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        WAIT: begin
          if (ms_valid && data_sram_data_ok) begin
            state_nxt     = DONE;
            rdata_capture = 1'b1;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ms_valid  <= 1'b0;
      bus_r     <= '0;
      state     <= IDLE;
      rdata_buf <= '0;
    end else begin
      if (ms_allowin) ms_valid <= es_to_ms_valid;
      if (accept) bus_r <= es_to_ms_bus;
      state <= state_nxt;
      if (rdata_capture) rdata_buf <= data_sram_rdata;
    end
  end

`ifdef MS_FORWARD_EN
  assign ms_fwd_valid = ms_valid && gr_we && (dest != 5'd0);
  assign ms_fwd_dest  = dest;
  assign ms_fwd_data  = final_result;
  assign ms_fwd_stall = ms_fwd_valid && res_from_mem && !ms_ready_go;
`else
  assign ms_fwd_valid = 1'b0;
  assign ms_fwd_dest  = '0;
  assign ms_fwd_data  = '0;
  assign ms_fwd_stall = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: per-cycle comparison against an instruction-level model, plus directed literal checks.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [74:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;
  logic        ms_fwd_stall;

  int checks = 0;
  int errors = 0;

  mem_stage #(.ES_TO_MS_BUS_WD(75), .MS_TO_WS_BUS_WD(70)) dut (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
    .ms_fwd_data(ms_fwd_data), .ms_fwd_stall(ms_fwd_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [74:0] mk(input logic mem_req, input logic [2:0] ld, input logic rfm,
                                     input logic we, input logic [4:0] dst, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {mem_req, ld, rfm, we, dst, alu, pc};
  endfunction

  // Load alignment from the instruction-set rules, in plain arithmetic.
  function automatic logic [31:0] extract(input logic [2:0] ld, input logic [31:0] addr, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (addr % 4))) & 32'hFF;
    h = ((addr % 4) >= 2) ? (w >> 16) : (w & 32'hFFFF);
    case (ld)
      3'd1:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd2:    return b;
      3'd3:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  // Model: the instruction held in the stage and whether its response has already been captured.
  logic        m_valid = 1'b0;
  logic [74:0] m_ins = '0;
  logic        m_got = 1'b0;
  logic [31:0] m_data = '0;

  always @(negedge clk) begin
    logic        mreq, rfm, we, ready, e_out, e_allow, e_fv, e_st;
    logic [2:0]  ld;
    logic [4:0]  dst;
    logic [31:0] alu, pc, src, fres;
    if (!resetn) begin
      m_valid = 1'b0; m_ins = '0; m_got = 1'b0; m_data = '0;
    end
    mreq = m_ins[74]; ld = m_ins[73:71]; rfm = m_ins[70]; we = m_ins[69];
    dst = m_ins[68:64]; alu = m_ins[63:32]; pc = m_ins[31:0];
    ready   = !mreq || m_got || (m_valid && data_sram_data_ok);
    e_out   = m_valid && ready;
    e_allow = !m_valid || (ready && ws_allowin);
    src     = m_got ? m_data : data_sram_rdata;
    fres    = rfm ? extract(ld, alu, src) : alu;
    chk("ms_allowin", {31'd0, ms_allowin}, {31'd0, e_allow});
    chk("ms_to_ws_valid", {31'd0, ms_to_ws_valid}, {31'd0, e_out});
    if (e_out) begin
      chk("ws.gr_we", {31'd0, ms_to_ws_bus[69]}, {31'd0, we});
      chk("ws.dest", {27'd0, ms_to_ws_bus[68:64]}, {27'd0, dst});
      chk("ws.final_result", ms_to_ws_bus[63:32], fres);
      chk("ws.pc", ms_to_ws_bus[31:0], pc);
    end
`ifdef MS_FORWARD_EN
    e_fv = m_valid && we && (dst != 0);
    e_st = e_fv && rfm && !ready;
    chk("fwd_valid", {31'd0, ms_fwd_valid}, {31'd0, e_fv});
    chk("fwd_stall", {31'd0, ms_fwd_stall}, {31'd0, e_st});
    if (e_fv) begin
      chk("fwd_dest", {27'd0, ms_fwd_dest}, {27'd0, dst});
      chk("fwd_data", ms_fwd_data, fres);
    end
`else
    e_fv = 1'b0;
    e_st = 1'b0;
    chk("fwd_off", {ms_fwd_valid, ms_fwd_stall, ms_fwd_dest, 25'd0}, {e_fv, e_st, 30'd0});
    chk("fwd_data_off", ms_fwd_data, 32'd0);
`endif
    // Advance the model to the state after the coming rising edge.
    if (resetn) begin
      if (m_valid && mreq && !m_got && data_sram_data_ok && !ws_allowin) begin
        m_got = 1'b1; m_data = data_sram_rdata;
      end
      if (e_allow) begin
        m_valid = es_to_ms_valid;
        if (es_to_ms_valid) begin
          m_ins = es_to_ms_bus; m_got = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic fast_load(input string name, input logic [2:0] ld, input logic [31:0] addr,
                           input logic [31:0] rd, input logic [31:0] exp);
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b1, ld, 1'b1, 1'b1, 5'd7, addr, 32'h200);
    step();
    es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = rd;
    @(negedge clk);
    chk({name, ".valid"}, {31'd0, ms_to_ws_valid}, 32'd1);
    chk({name, ".result"}, ms_to_ws_bus[63:32], exp);
    step();
    data_sram_data_ok = 1'b0;
  endtask

  typedef struct { logic [74:0] bus; logic ws; } vec_t;
  vec_t tbl[8];

  initial begin
    resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    @(negedge clk);
    chk("reset.allowin", {31'd0, ms_allowin}, 32'd1);
    chk("reset.valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("reset.bus_lo", ms_to_ws_bus[31:0], 32'd0);
    chk("reset.bus_hi", {ms_to_ws_bus[69:64], ms_to_ws_bus[63:38]}, 32'd0);
    step(); step();
    resetn = 1'b1;
    step();

    // ALU instruction: one cycle through, visible for exactly one cycle.
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h12345678, 32'h100);
    step();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    chk("alu.valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("alu.result", ms_to_ws_bus[63:32], 32'h12345678);
    chk("alu.dest", {27'd0, ms_to_ws_bus[68:64]}, 32'd5);
    step();
    @(negedge clk);
    chk("alu.one_cycle", {31'd0, ms_to_ws_valid}, 32'd0);
    step();

    fast_load("lb",  3'd1, 32'h1003, 32'h80FF1234, 32'hFFFFFF80);
    fast_load("lbu", 3'd2, 32'h1003, 32'h80FF1234, 32'h00000080);
    fast_load("lh",  3'd3, 32'h1002, 32'h80FF1234, 32'hFFFF80FF);
    fast_load("lhu", 3'd4, 32'h1002, 32'h80FF1234, 32'h000080FF);
    fast_load("lb0", 3'd1, 32'h1000, 32'h80FF1234, 32'h00000034);
    fast_load("lt7", 3'd7, 32'h1001, 32'h80FF1234, 32'h80FF1234);

    // LW with the response three cycles late.
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd9, 32'h2000, 32'h300);
    step();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lwwait.valid", {31'd0, ms_to_ws_valid}, 32'd0);
      chk("lwwait.allowin", {31'd0, ms_allowin}, 32'd0);
`ifdef MS_FORWARD_EN
      chk("lwwait.stall", {31'd0, ms_fwd_stall}, 32'd1);
`endif
      step();
    end
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("lwwait.done", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("lwwait.result", ms_to_ws_bus[63:32], 32'hCAFEF00D);
    step();
    data_sram_data_ok = 1'b0;

    // Response arrives while writeback is stalled, then the SRAM data bus changes.
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd10, 32'h3000, 32'h400);
    step();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("buf.allowin", {31'd0, ms_allowin}, 32'd0);
    step();
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
    @(negedge clk);
    chk("buf.held", ms_to_ws_bus[63:32], 32'hDEADBEEF);
    step();
    ws_allowin = 1'b1;
    @(negedge clk);
    chk("buf.valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("buf.result", ms_to_ws_bus[63:32], 32'hDEADBEEF);
    step();

    // Store waits for its response like a load but reports alu_result.
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b1, 3'd0, 1'b0, 1'b0, 5'd0, 32'h4444, 32'h500);
    step();
    es_to_ms_valid = 1'b0;
    step();
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h99999999;
    @(negedge clk);
    chk("store.result", ms_to_ws_bus[63:32], 32'h4444);
    step();
    data_sram_data_ok = 1'b0;

    // Reset while waiting, then a late response must be ignored.
    es_to_ms_valid = 1'b1; es_to_ms_bus = mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd3, 32'h5000, 32'h600);
    step();
    es_to_ms_valid = 1'b0;
    step();
    resetn = 1'b0;
    @(negedge clk);
    chk("rst.allowin", {31'd0, ms_allowin}, 32'd1);
    chk("rst.valid", {31'd0, ms_to_ws_valid}, 32'd0);
    step();
    resetn = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111;
    @(negedge clk);
    chk("stray.valid", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("stray.allowin", {31'd0, ms_allowin}, 32'd1);
    chk("stray.bus", ms_to_ws_bus[63:32], 32'd0);
    step();
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    chk("stray.after", {31'd0, ms_to_ws_valid}, 32'd0);
    step();

    // Back-to-back mix under writeback back-pressure; checked by the model only.
    tbl[0] = '{mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd1,  32'hA0A0A0A0, 32'h700), 1'b0};
    tbl[1] = '{mk(1'b1, 3'd3, 1'b1, 1'b1, 5'd2,  32'h00000002, 32'h704), 1'b1};
    tbl[2] = '{mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd0,  32'h0000BEEF, 32'h708), 1'b1};
    tbl[3] = '{mk(1'b1, 3'd2, 1'b1, 1'b1, 5'd4,  32'h00000001, 32'h70C), 1'b0};
    tbl[4] = '{mk(1'b1, 3'd0, 1'b0, 1'b0, 5'd6,  32'h00001234, 32'h710), 1'b1};
    tbl[5] = '{mk(1'b1, 3'd4, 1'b1, 1'b1, 5'd8,  32'h00000003, 32'h714), 1'b0};
    tbl[6] = '{mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd31, 32'h76543210, 32'h718), 1'b1};
    tbl[7] = '{mk(1'b1, 3'd1, 1'b1, 1'b1, 5'd12, 32'h00000002, 32'h71C), 1'b1};
    begin
      int idx = 0;
      int cyc = 0;
      logic acc;
      while (idx < 8 && cyc < 200) begin
        es_to_ms_valid = 1'b1; es_to_ms_bus = tbl[idx].bus;
        ws_allowin = tbl[idx].ws | (cyc % 3 == 0);
        data_sram_data_ok = (cyc % 2 == 1);
        data_sram_rdata = 32'h13579BDF ^ (cyc * 32'h01020304);
        @(negedge clk);
        acc = ms_allowin;
        step();
        if (acc) idx++;
        cyc++;
      end
      chk("mix.issued", idx, 32'd8);
      es_to_ms_valid = 1'b0; ws_allowin = 1'b1;
      for (int i = 0; i < 6; i++) begin
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hF00DF00D + i;
        step();
      end
      data_sram_data_ok = 1'b0;
      @(negedge clk);
      chk("mix.drained", {31'd0, ms_to_ws_valid}, 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
